// File: rtl/tap_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tap_shifter
// Purpose  : Sample delay line that writes the parallel taps window used by
//            the wavelet fir bank. Samples arrive over a valid/ready
//            handshake. Each accepted sample shifts into an NUM_ELEM-deep
//            chain. A one-cycle strobe marks the window as full and fresh.
//
// Ports    : clk           in   sole clock, rising edge
//            rst_n         in   asynchronous active-low reset
//            i_sample      in   BITS_PER_ELEM two's-complement sample
//            i_valid       in   i_sample is offered
//            o_ready       out  sample accepted this cycle if i_valid
//            i_flush       in   single-cycle request to zero the window
//            taps          out  packed window; element k = sample k accepts ago
//            o_taps_valid  out  one-cycle strobe: taps full and fresh
//            o_fill        out  valid element count, saturating at NUM_ELEM
//
// Option   : TAP_DECIM_EN  when defined, the strobe is decimated by DECIM
//                          while the window stays full. When undefined,
//                          DECIM is ignored.
//
// Revision : 1.0  initial release
// ============================================================================
module tap_shifter #(
    parameter int BITS_PER_ELEM = 8,
    parameter int NUM_ELEM      = 7,
    parameter int DECIM         = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [BITS_PER_ELEM-1:0]           i_sample,
    input  logic                               i_valid,
    output logic                               o_ready,
    input  logic                               i_flush,
    output logic [NUM_ELEM*BITS_PER_ELEM-1:0]  taps,
    output logic                               o_taps_valid,
    output logic [$clog2(NUM_ELEM+1)-1:0]      o_fill
);

    localparam int c_FW  = $clog2(NUM_ELEM + 1);
    localparam int c_CW  = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
    localparam int c_TW  = NUM_ELEM * BITS_PER_ELEM;

    // Fill value just before the window becomes complete.
    localparam logic [c_FW-1:0] c_FILL_LAST  = c_FW'(NUM_ELEM - 1);
    // Last flush cycle index (counter runs 0..NUM_ELEM-1).
    localparam logic [c_CW-1:0] c_FLUSH_LAST = c_CW'(NUM_ELEM - 1);

    // A decimation factor below 1 has no meaning. This block is left empty
    // on purpose: it only exists so that a bad DECIM is easy to spot here.
    if (DECIM < 1) begin : g_decim_range_check
    end

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                 state_q,       state_d;
    logic [c_TW-1:0]        taps_q,        taps_d;
    logic [c_FW-1:0]        fill_q,        fill_d;
    logic [c_CW-1:0]        flush_cnt_q,   flush_cnt_d;
    logic                   ready_q,       ready_d;
    logic                   taps_valid_q,  taps_valid_d;

    logic                   w_accept;

    // o_ready is registered, so it is already 0 throughout FLUSH. That
    // gives the "i_valid ignored while flushing" behaviour for free.
    assign w_accept = i_valid && ready_q;

    // Element k takes element k-1. Element 0 takes the new value, and the
    // oldest element falls off the end.
    function automatic logic [c_TW-1:0] shift_in(
        input logic [c_TW-1:0]          win,
        input logic [BITS_PER_ELEM-1:0] smp
    );
        logic [c_TW-1:0] res;
        res = win;
        for (int k = NUM_ELEM - 1; k > 0; k--) begin
            res[BITS_PER_ELEM*k +: BITS_PER_ELEM] =
                win[BITS_PER_ELEM*(k-1) +: BITS_PER_ELEM];
        end
        res[0 +: BITS_PER_ELEM] = smp;
        return res;
    endfunction

`ifdef TAP_DECIM_EN
    localparam int c_DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [c_DW-1:0] c_DECIM_LAST = c_DW'(DECIM - 1);

    logic [c_DW-1:0] decim_cnt_q, decim_cnt_d;
    logic [c_DW-1:0] w_decim_next;

    // Modulo-DECIM accept counter. It wraps to 0 on every DECIM-th accept
    // after the filling accept, and that wrap is when the strobe fires.
    assign w_decim_next = (decim_cnt_q == c_DECIM_LAST) ? '0
                                                        : decim_cnt_q + 1'b1;
`endif

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        taps_d       = taps_q;
        fill_d       = fill_q;
        flush_cnt_d  = flush_cnt_q;
        ready_d      = ready_q;
        taps_valid_d = 1'b0;
`ifdef TAP_DECIM_EN
        decim_cnt_d  = decim_cnt_q;
`endif

        if (i_flush) begin
            // A flush overrides everything. If an accept coincides with it,
            // the handshake completes but the sample is dropped and no
            // strobe is issued. During FLUSH, the zero shift of this cycle
            // still happens and the cycle count restarts.
            state_d     = ST_FLUSH;
            fill_d      = '0;
            flush_cnt_d = '0;
            ready_d     = 1'b0;
            if (state_q == ST_FLUSH) begin
                taps_d = shift_in(taps_q, '0);
            end
`ifdef TAP_DECIM_EN
            decim_cnt_d = '0;
`endif
        end else begin
            case (state_q)
                ST_FILL: begin
                    ready_d = 1'b1;
                    if (w_accept) begin
                        taps_d = shift_in(taps_q, i_sample);
                        fill_d = fill_q + 1'b1;
                        if (fill_q == c_FILL_LAST) begin
                            state_d      = ST_RUN;
                            taps_valid_d = 1'b1;
`ifdef TAP_DECIM_EN
                            decim_cnt_d  = '0;
`endif
                        end
                    end
                end

                ST_RUN: begin
                    ready_d = 1'b1;
                    if (w_accept) begin
                        taps_d = shift_in(taps_q, i_sample);
`ifdef TAP_DECIM_EN
                        decim_cnt_d  = w_decim_next;
                        taps_valid_d = (w_decim_next == '0);
`else
                        taps_valid_d = 1'b1;
`endif
                    end
                end

                ST_FLUSH: begin
                    // One zero shifts in per cycle. After NUM_ELEM cycles,
                    // every element has been overwritten.
                    taps_d = shift_in(taps_q, '0);
                    if (flush_cnt_q == c_FLUSH_LAST) begin
                        state_d     = ST_FILL;
                        flush_cnt_d = '0;
                        ready_d     = 1'b1;
                    end else begin
                        flush_cnt_d = flush_cnt_q + 1'b1;
                        ready_d     = 1'b0;
                    end
                end

                default: begin
                    // Unreachable encoding: recover to an empty window.
                    state_d     = ST_FILL;
                    taps_d      = '0;
                    fill_d      = '0;
                    flush_cnt_d = '0;
                    ready_d     = 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_FILL;
            taps_q       <= '0;
            fill_q       <= '0;
            flush_cnt_q  <= '0;
            ready_q      <= 1'b1;
            taps_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            taps_q       <= taps_d;
            fill_q       <= fill_d;
            flush_cnt_q  <= flush_cnt_d;
            ready_q      <= ready_d;
            taps_valid_q <= taps_valid_d;
        end
    end

`ifdef TAP_DECIM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decim_cnt_q <= '0;
        end else begin
            decim_cnt_q <= decim_cnt_d;
        end
    end
`endif

    assign taps         = taps_q;
    assign o_fill       = fill_q;
    assign o_ready      = ready_q;
    assign o_taps_valid = taps_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_tap_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tap_shifter
// Purpose  : Self-checking bench for tap_shifter. It runs directed steps from
//            the test plan, followed by random traffic. Every output is
//            compared each cycle against a window/queue reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_tap_shifter;

    localparam int B  = 8;
    localparam int NE = 7;
    localparam int DECIM = 2;
`ifdef TAP_DECIM_EN
    localparam bit DECIM_ON = 1'b1;
`else
    localparam bit DECIM_ON = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic [B-1:0]      i_sample;
    logic              i_valid;
    logic              o_ready;
    logic              i_flush;
    logic [NE*B-1:0]   taps;
    logic              o_taps_valid;
    logic [2:0]        o_fill;

    int checks;
    int failures;

    tap_shifter #(
        .BITS_PER_ELEM (B),
        .NUM_ELEM      (NE),
        .DECIM         (DECIM)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sample     (i_sample),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_flush      (i_flush),
        .taps         (taps),
        .o_taps_valid (o_taps_valid),
        .o_fill       (o_fill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // m_win[0] = newest sample. m_flush_left = remaining zeroing cycles.
    // m_full_accepts = accepts that left the window full since it last began
    // filling.
    logic [B-1:0] m_win [NE];
    int           m_fill;
    int           m_flush_left;
    int           m_full_accepts;
    bit           m_tv;

    task automatic model_reset();
        for (int k = 0; k < NE; k++) m_win[k] = '0;
        m_fill = 0;
        m_flush_left = 0;
        m_full_accepts = 0;
        m_tv = 1'b0;
    endtask

    task automatic model_push(input logic [B-1:0] s);
        for (int k = NE - 1; k > 0; k--) m_win[k] = m_win[k-1];
        m_win[0] = s;
    endtask

    task automatic model_edge(input bit v, input logic [B-1:0] s, input bit f);
        bit acc;
        acc  = v && (m_flush_left == 0);
        m_tv = 1'b0;
        if (f) begin
            if (m_flush_left > 0) model_push('0);
            m_flush_left   = NE;
            m_fill         = 0;
            m_full_accepts = 0;
        end else if (m_flush_left > 0) begin
            model_push('0);
            m_flush_left--;
        end else if (acc) begin
            model_push(s);
            if (m_fill < NE) m_fill++;
            if (m_fill == NE) begin
                m_full_accepts++;
                m_tv = DECIM_ON ? (((m_full_accepts - 1) % DECIM) == 0) : 1'b1;
            end
        end
    endtask

    function automatic logic [NE*B-1:0] model_taps();
        logic [NE*B-1:0] r;
        for (int k = 0; k < NE; k++) r[B*k +: B] = m_win[k];
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check_all(input string tag);
        logic [NE*B-1:0] et;
        logic [2:0]      ef;
        logic            er;
        et = model_taps();
        ef = 3'(m_fill);
        er = (m_flush_left == 0);
        checks++;
        assert (taps === et) else begin
            failures++;
            $error("FAIL %s taps observed=%h expected=%h", tag, taps, et);
        end
        checks++;
        assert (o_fill === ef) else begin
            failures++;
            $error("FAIL %s o_fill observed=%0d expected=%0d", tag, o_fill, ef);
        end
        checks++;
        assert (o_taps_valid === m_tv) else begin
            failures++;
            $error("FAIL %s o_taps_valid observed=%b expected=%b", tag, o_taps_valid, m_tv);
        end
        checks++;
        assert (o_ready === er) else begin
            failures++;
            $error("FAIL %s o_ready observed=%b expected=%b", tag, o_ready, er);
        end
    endtask

    task automatic check_elem(input string tag, input int k, input logic [B-1:0] exp);
        logic [B-1:0] got;
        got = taps[B*k +: B];
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s elem%0d observed=%h expected=%h", tag, k, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, step the model at the edge, compare at +1.
    task automatic cycle(input bit v, input logic [B-1:0] s, input bit f, input string tag);
        i_valid  = v;
        i_sample = s;
        i_flush  = f;
        @(posedge clk);
        model_edge(v, s, f);
        #1;
        check_all(tag);
    endtask

    // Reset asserted mid-cycle. Outputs must clear before the next edge.
    task automatic async_reset(input string tag);
        i_valid = 1'b0;
        i_flush = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_flush  = 1'b0;
        i_sample = '0;
        model_reset();
        #12;
        check_all("por");
        #1;
        rst_n = 1'b1;

        // Reset pulsed mid-operation.
        cycle(1'b1, 8'h55, 1'b0, "pre_rst");
        async_reset("rst_mid");

        // Fill the window with 0x01..0x07.
        for (int i = 1; i <= NE; i++) cycle(1'b1, 8'(i), 1'b0, "fill");
        check_elem("fill", 0, 8'h07);
        check_elem("fill", 6, 8'h01);
        check_bit("fill_strobe", o_taps_valid, 1'b1);

        // Steady stream with 3-cycle gaps.
        cycle(1'b1, 8'h80, 1'b0, "s80");
        for (int g = 0; g < 3; g++) cycle(1'b0, 8'($urandom), 1'b0, "gap1");
        cycle(1'b1, 8'h7F, 1'b0, "s7f");
        check_bit("s7f_strobe", o_taps_valid, 1'b1);
        for (int g = 0; g < 3; g++) cycle(1'b0, 8'($urandom), 1'b0, "gap2");
        cycle(1'b1, 8'hFF, 1'b0, "sff");
        check_elem("sff", 0, 8'hFF);
        check_elem("sff", 6, 8'h04);
        check_bit("sff_strobe", o_taps_valid, !DECIM_ON);

        // Flush mid-stream with a coincident valid sample.
        cycle(1'b1, 8'hAA, 1'b1, "flush_edge");
        check_elem("flush_drop", 0, 8'hFF);
        for (int c = 0; c < NE; c++) cycle(1'b1, 8'($urandom), 1'b0, "flushing");
        check_bit("flush_done_ready", o_ready, 1'b1);
        checks++;
        assert (taps === '0) else begin
            failures++;
            $error("FAIL flush_zero taps observed=%h expected=0", taps);
        end
        for (int i = 0; i < NE; i++) cycle(1'b1, 8'($urandom), 1'b0, "refill");
        check_bit("refill_strobe", o_taps_valid, 1'b1);

        // Repeated flush: second request on cycle 4 of FLUSH.
        cycle(1'b0, 8'h00, 1'b1, "rflush1");
        for (int c = 0; c < 3; c++) cycle(1'b0, 8'h00, 1'b0, "rflush_a");
        cycle(1'b1, 8'h11, 1'b1, "rflush2");
        for (int c = 0; c < NE; c++) begin
            check_bit("rflush_low", o_ready, 1'b0);
            cycle(1'b1, 8'($urandom), 1'b0, "rflush_b");
        end
        check_bit("rflush_high", o_ready, 1'b1);

        // Async reset during a full stream, then refill.
        for (int i = 0; i < NE + 3; i++) cycle(1'b1, 8'($urandom), 1'b0, "stream");
        async_reset("rst_stream");
        for (int i = 0; i < NE; i++) cycle(1'b1, 8'($urandom), 1'b0, "rst_refill");
        check_bit("rst_refill_strobe", o_taps_valid, 1'b1);

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            cycle(($urandom_range(0, 9) < 7), 8'($urandom),
                  ($urandom_range(0, 39) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tap_shifter.md
# tap_shifter

Sample-delay line that produces the parallel `taps` bus consumed by the wavelet `fir` filter bank. It accepts a stream of signed samples over a valid/ready handshake and shifts each into an `NUM_ELEM`-deep register chain. It presents the chain as a packed `taps` vector and flags when the window is fully populated and fresh. It is the writer side of the `taps` interface, and one instance fans out to every `fir` in the bank.

## Interface
- `BITS_PER_ELEM`, 8, width of one sample and of one taps element.
- `NUM_ELEM`, 7, window depth; must equal the `fir` instances' `NUM_ELEM`.
- `DECIM`, 2, output decimation factor; used only when `TAP_DECIM_EN` is defined; must be ≥1.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_sample`  in  `BITS_PER_ELEM`  two's-complement sample.
- `i_valid`  in  1  `i_sample` is offered.
- `o_ready`  out  1  block accepts a sample this cycle.
- `i_flush`  in  1  single-cycle request to zero the window.
- `taps`  out  `NUM_ELEM*BITS_PER_ELEM`  window; element k at `[BITS_PER_ELEM*k +: BITS_PER_ELEM]` holds the sample accepted k accepts ago.
- `o_taps_valid`  out  1  one-cycle strobe: `taps` is full and fresh.
- `o_fill`  out  `$clog2(NUM_ELEM+1)`  count of valid elements, saturating at `NUM_ELEM`.

## Operation
- Accept occurs when `i_valid && o_ready` at a rising edge.
- On accept, element k takes element k-1, element 0 takes `i_sample`, and element `NUM_ELEM-1` is discarded. Samples pass bit-exact, with no sign or width change.
- `o_fill` increments per accept and saturates at `NUM_ELEM`.
- The FSM has three states:
  - FILL: `o_fill < NUM_ELEM`, `o_ready=1`. Moves to RUN on the accept that brings `o_fill` to `NUM_ELEM`.
  - RUN: `o_ready=1`.
  - FLUSH: `o_ready=0`. Zeros shift into element 0 once per cycle for `NUM_ELEM` cycles, then the FSM moves to FILL.
- `i_flush` is honoured in any state and moves the FSM to FLUSH on the next edge. `o_fill` clears to 0 at that edge, and the flush cycle counter restarts.
- If `i_flush` coincides with an accept, the handshake completes but the sample is discarded, and no strobe is issued.
- `i_flush` arriving during FLUSH restarts the `NUM_ELEM`-cycle count.
- `i_valid` is ignored while in FLUSH.
- `o_taps_valid` asserts after an accept that leaves `o_fill == NUM_ELEM`. It is gated by decimation, as described under Configuration.
- When no accept occurs, `taps` and `o_fill` hold.

## Timing
- Reset values: `taps=0`, `o_fill=0`, `o_taps_valid=0`, `o_ready=1`, state FILL.
- Reset takes effect immediately on `rst_n` falling, mid-operation included. Deassertion is synchronised externally.
- Latency from accept edge to the updated `taps`: 0 cycles, meaning the value is visible right after that edge.
- `o_taps_valid` is registered and is high for exactly the cycle following the accept edge, aligned with the new `taps`. `fir` registers its sum on that same next edge.
- `o_ready` is registered. It falls in the cycle after `i_flush` is sampled and rises after the `NUM_ELEM`-th flush cycle.
- Back-to-back accepts are sustained at one sample per cycle, with no bubbles outside FLUSH.

## Configuration
- `TAP_DECIM_EN` defined:
  - A modulo-`DECIM` counter of accepts runs in RUN.
  - It is reset to 0 by reset, by flush, and by the FILL→RUN transition accept.
  - `o_taps_valid` fires on the accept that fills the window and then on every `DECIM`-th accept after it.
- `TAP_DECIM_EN` undefined: there is no counter, `DECIM` is ignored, and `o_taps_valid` fires after every accept while full.

## Test plan
All scenarios use `NUM_ELEM=7`, `BITS_PER_ELEM=8`, `DECIM=2`.
- Reset: pulse `rst_n` low mid-clock → outputs go immediately to `taps=0`, `o_fill=0`, `o_taps_valid=0`, `o_ready=1`.
- Fill: accept 0x01..0x07 back-to-back → `o_fill` steps 1..7, one `o_taps_valid` pulse after the 7th accept, element 0 = 0x07, element 6 = 0x01.
- Steady stream: accept 0x80, 0x7F, 0xFF, with a 3-cycle `i_valid` gap between each.
  - `taps` holds during the gaps.
  - After 0xFF, element 0 = 0xFF and element 6 = 0x04.
  - `o_taps_valid` pulses after each accept with the macro undefined. With it defined, it pulses only after 0x7F.
- Flush mid-stream: assert `i_flush` with `i_valid=1`.
  - `o_ready=0` for 7 cycles, then `taps=0` and `o_fill=0`.
  - The coincident sample does not appear in `taps`.
  - Seven new accepts are needed before the next strobe.
- Repeated flush: a second `i_flush` on cycle 4 of FLUSH → `o_ready` stays low for 7 cycles after it.
- Async reset during a full stream → all outputs clear the same cycle, and refilling yields the first strobe after 7 accepts.
